// File: rtl/seq_mono_det_if.sv
// Stream bundle for seq_mono_det: sample strobe/data/mode in, result flag out.
// The hit_cnt signal exists only when SEQ_MONO_HITCNT_EN is defined.
interface seq_mono_det_if #(
   parameter int DATA_W = 4
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic [1:0]        mode;
   logic              out_valid;
   logic              out_data;
`ifdef SEQ_MONO_HITCNT_EN
   logic [7:0]        hit_cnt;

   modport master (output in_valid, in_data, mode, input out_valid, out_data, hit_cnt);
   modport slave  (input in_valid, in_data, mode, output out_valid, out_data, hit_cnt);
`else
   modport master (output in_valid, in_data, mode, input out_valid, out_data);
   modport slave  (input in_valid, in_data, mode, output out_valid, out_data);
`endif
endinterface

// File: rtl/seq_mono_det.sv
// Streaming monotonic-run detector: flags every sample whose last RUN_LEN frame samples obey the latched mode.
// Optional per-frame hit counter on bus.hit_cnt when SEQ_MONO_HITCNT_EN is defined.
module seq_mono_det #(
   parameter int DATA_W  = 4,
   parameter int RUN_LEN = 3,
   parameter int FRM_W   = 8
) (
   input logic           clk,
   input logic           rst_n,
   seq_mono_det_if.slave bus
);
   localparam int CNT_W = $clog2(RUN_LEN);
   localparam logic [CNT_W-1:0] RUN_MAX       = CNT_W'(RUN_LEN - 1);
   localparam logic [FRM_W-1:0] POS_LAST_FILL = FRM_W'(RUN_LEN - 1);
   localparam logic [FRM_W-1:0] POS_MAX       = '1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;

   localparam logic [1:0] MODE_INC    = 2'd0;
   localparam logic [1:0] MODE_DEC    = 2'd1;
   localparam logic [1:0] MODE_EITHER = 2'd2;
   localparam logic [1:0] MODE_EQ     = 2'd3;

   logic [1:0]        state;
   logic [DATA_W-1:0] prev;
   logic [FRM_W-1:0]  pos;
   logic [1:0]        mode_q;
   logic [CNT_W-1:0]  inc_run, dec_run, eq_run;
   logic [CNT_W-1:0]  inc_nxt, dec_nxt, eq_nxt;
   logic              hit;
   logic              emit;
   logic              out_valid_q, out_data_q;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      inc_nxt = '0;
      dec_nxt = '0;
      eq_nxt  = '0;
      if (bus.in_data > prev)
         inc_nxt = (inc_run == RUN_MAX) ? RUN_MAX : inc_run + CNT_W'(1);
      else if (bus.in_data < prev)
         dec_nxt = (dec_run == RUN_MAX) ? RUN_MAX : dec_run + CNT_W'(1);
      else
         eq_nxt  = (eq_run == RUN_MAX) ? RUN_MAX : eq_run + CNT_W'(1);
   end

   always_comb begin
      hit = 1'b0;
      case (mode_q)
         MODE_INC:    hit = (inc_nxt == RUN_MAX);
         MODE_DEC:    hit = (dec_nxt == RUN_MAX);
         MODE_EITHER: hit = (inc_nxt == RUN_MAX) || (dec_nxt == RUN_MAX);
         MODE_EQ:     hit = (eq_nxt == RUN_MAX);
         default:     hit = 1'b0;
      endcase
   end

   // A sample qualifies once it is at least the RUN_LEN-th of its frame.
   assign emit = bus.in_valid && ((state == RUN) || ((state == FILL) && (pos == POS_LAST_FILL)));

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         prev        <= '0;
         pos         <= '0;
         mode_q      <= '0;
         inc_run     <= '0;
         dec_run     <= '0;
         eq_run      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 1'b0;
      end else begin
         out_valid_q <= emit;
         out_data_q  <= emit && hit;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  state   <= FILL;
                  prev    <= bus.in_data;
                  pos     <= FRM_W'(1);
                  mode_q  <= bus.mode;
                  inc_run <= '0;
                  dec_run <= '0;
                  eq_run  <= '0;
               end
            end
            FILL, RUN: begin
               if (bus.in_valid) begin
                  prev    <= bus.in_data;
                  inc_run <= inc_nxt;
                  dec_run <= dec_nxt;
                  eq_run  <= eq_nxt;
                  if (pos != POS_MAX)
                     pos <= pos + FRM_W'(1);
                  if ((state == FILL) && (pos == POS_LAST_FILL))
                     state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

`ifdef SEQ_MONO_HITCNT_EN
   logic [7:0] hit_cnt;

   // Cleared by the first sample of a frame, held between frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hit_cnt <= '0;
      else if ((state == IDLE) && bus.in_valid)
         hit_cnt <= '0;
      else if (emit && hit && (hit_cnt != 8'hFF))
         hit_cnt <= hit_cnt + 8'd1;
   end

   assign bus.hit_cnt = hit_cnt;
`endif

endmodule

// File: tb/tb_seq_mono_det.sv
// Self-checking bench for seq_mono_det: two instances (4-bit/run 3 and 8-bit/run 4), vector table,
// hand sequences and random frames against a window-based reference model. Honours SEQ_MONO_HITCNT_EN.
`timescale 1ns/1ps
module tb_seq_mono_det;
   localparam int A_W   = 4;
   localparam int A_RUN = 3;
   localparam int B_W   = 8;
   localparam int B_RUN = 4;
   localparam int FRM_W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   seq_mono_det_if #(.DATA_W(A_W)) bus_a ();
   seq_mono_det_if #(.DATA_W(B_W)) bus_b ();

   seq_mono_det #(.DATA_W(A_W), .RUN_LEN(A_RUN), .FRM_W(FRM_W)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   seq_mono_det #(.DATA_W(B_W), .RUN_LEN(B_RUN), .FRM_W(FRM_W)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   int checks = 0;
   int errors = 0;

   // Reference model: the last 16 samples of the frame, and the frame length so far.
   int run_len [2];
   int hist [2][16];
   int frame_len [2];
   bit in_frame [2];
   int fmode [2];
   int hits [2];
   bit ev [2];
   bit ed [2];

   typedef struct {
      bit v;
      int d;
      int m;
      bit exp_v;
      bit exp_d;
   } vec_t;

   vec_t tbl [26];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit run_ok(input int id);
      bit up = 1'b1;
      bit dn = 1'b1;
      bit eq = 1'b1;
      for (int i = 16 - run_len[id] + 1; i < 16; i++) begin
         if (!(hist[id][i] > hist[id][i-1]))  up = 1'b0;
         if (!(hist[id][i] < hist[id][i-1]))  dn = 1'b0;
         if (hist[id][i] != hist[id][i-1])    eq = 1'b0;
      end
      case (fmode[id])
         0:       return up;
         1:       return dn;
         2:       return up | dn;
         default: return eq;
      endcase
   endfunction

   task automatic model_step(input int id, input bit v, input int d, input int m);
      if (!v) begin
         in_frame[id] = 1'b0;
         ev[id] = 1'b0;
         ed[id] = 1'b0;
      end else begin
         if (!in_frame[id]) begin
            in_frame[id]  = 1'b1;
            frame_len[id] = 0;
            fmode[id]     = m;
            hits[id]      = 0;
         end
         for (int i = 0; i < 15; i++) hist[id][i] = hist[id][i+1];
         hist[id][15] = d;
         frame_len[id]++;
         ev[id] = (frame_len[id] >= run_len[id]);
         ed[id] = ev[id] && run_ok(id);
         if (ed[id] && hits[id] < 255) hits[id]++;
      end
   endtask

   task automatic model_reset();
      for (int id = 0; id < 2; id++) begin
         in_frame[id] = 1'b0;
         ev[id] = 1'b0;
         ed[id] = 1'b0;
         hits[id] = 0;
      end
   endtask

   task automatic compare(input string tag);
      check({tag, "_a_out"}, {bus_a.out_valid, bus_a.out_data}, {ev[0], ed[0]});
      check({tag, "_b_out"}, {bus_b.out_valid, bus_b.out_data}, {ev[1], ed[1]});
`ifdef SEQ_MONO_HITCNT_EN
      check({tag, "_a_hit_cnt"}, bus_a.hit_cnt, hits[0]);
      check({tag, "_b_hit_cnt"}, bus_b.hit_cnt, hits[1]);
`endif
   endtask

   task automatic step(input string tag, input bit va, input int da, input int ma,
                       input bit vb, input int db, input int mb);
      bus_a.in_valid = va;
      bus_a.in_data  = A_W'(da);
      bus_a.mode     = 2'(ma);
      bus_b.in_valid = vb;
      bus_b.in_data  = B_W'(db);
      bus_b.mode     = 2'(mb);
      model_step(0, va, da & ((1 << A_W) - 1), ma);
      model_step(1, vb, db & ((1 << B_W) - 1), mb);
      @(posedge clk);
      #1;
      compare(tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_a"}, {bus_a.out_valid, bus_a.out_data}, 0);
      check({tag, "_b"}, {bus_b.out_valid, bus_b.out_data}, 0);
`ifdef SEQ_MONO_HITCNT_EN
      check({tag, "_a_hit"}, bus_a.hit_cnt, 0);
      check({tag, "_b_hit"}, bus_b.hit_cnt, 0);
`endif
   endtask

   initial begin
      run_len[0] = A_RUN;
      run_len[1] = B_RUN;
      model_reset();
      bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.mode = '0;
      bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.mode = '0;

      // Power-on reset.
      #1 rst_n = 1'b0;
      #2 check_reset_outputs("reset_state");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      tbl = '{
         // increasing: 1,3,5,4,6,9
         '{1, 1, 0, 0, 0}, '{1, 3, 0, 0, 0}, '{1, 5, 0, 1, 1}, '{1, 4, 0, 1, 0},
         '{1, 6, 0, 1, 0}, '{1, 9, 0, 1, 1}, '{0, 0, 0, 0, 0},
         // decreasing: F,A,2,2,1,0
         '{1, 15, 1, 0, 0}, '{1, 10, 1, 0, 0}, '{1, 2, 1, 1, 1}, '{1, 2, 1, 1, 0},
         '{1, 1, 1, 1, 0}, '{1, 0, 1, 1, 1}, '{0, 0, 0, 0, 0},
         // either: 2,5,8 | idle | 7,4 (short)
         '{1, 2, 2, 0, 0}, '{1, 5, 2, 0, 0}, '{1, 8, 2, 1, 1}, '{0, 0, 0, 0, 0},
         '{1, 7, 2, 0, 0}, '{1, 4, 2, 0, 0}, '{0, 0, 0, 0, 0},
         // equal: mode flips to 00 after the first sample and must be ignored
         '{1, 6, 3, 0, 0}, '{1, 6, 0, 0, 0}, '{1, 6, 0, 1, 1}, '{1, 6, 0, 1, 1},
         '{0, 0, 0, 0, 0}
      };
      for (int i = 0; i < 26; i++) begin
         step("tbl", tbl[i].v, tbl[i].d, tbl[i].m, 1'b0, 0, 0);
         check($sformatf("tbl%0d_out", i), {bus_a.out_valid, bus_a.out_data}, {tbl[i].exp_v, tbl[i].exp_d});
`ifdef SEQ_MONO_HITCNT_EN
         if (i == 13) check("tbl_dec_hit_cnt", bus_a.hit_cnt, 2);
`endif
      end

      // Reset mid-frame: nothing may come out for the aborted frame or the lone sample after it.
      step("pre_rst", 1'b1, 1, 0, 1'b1, 7, 0);
      step("pre_rst", 1'b1, 2, 0, 1'b1, 8, 0);
      rst_n = 1'b0;
      model_reset();
      #1 check_reset_outputs("rst_async");
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("rst_held");
      @(negedge clk) rst_n = 1'b1;
      step("post_rst", 1'b1, 3, 0, 1'b1, 9, 0);
      step("post_rst", 1'b0, 0, 0, 1'b0, 0, 0);
      check("post_rst_a_quiet", {bus_a.out_valid, bus_a.out_data}, 0);

      // Long increasing ramp on the 8-bit instance, saturating position counter; repeats break the run.
      for (int i = 0; i < 300; i++)
         step("ramp", 1'b0, 0, 0, 1'b1, (i < 256) ? i : 255, 0);
      check("ramp_last_break", {bus_b.out_valid, bus_b.out_data}, 2'b10);
      step("ramp_end", 1'b0, 0, 0, 1'b0, 0, 0);

      // Long equal frame drives the hit counter into saturation.
      for (int i = 0; i < 300; i++)
         step("flat", 1'b0, 0, 0, 1'b1, 90, 3);
      step("flat_end", 1'b0, 0, 0, 1'b0, 0, 0);
`ifdef SEQ_MONO_HITCNT_EN
      check("flat_hit_cnt_sat", bus_b.hit_cnt, 255);
`endif

      // Random frames on both instances, narrow data range so equal/monotonic runs occur often.
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            @(negedge clk) rst_n = 1'b0;
            model_reset();
            #1 check_reset_outputs("rnd_rst");
            @(negedge clk) rst_n = 1'b1;
         end
         step("rnd",
              ($urandom_range(0, 7) != 0), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 9) != 0), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      end
      step("rnd_end", 1'b0, 0, 0, 1'b0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
